can_acf_multi_event_sync: RTL and testbench
===========================================

# can_acf_multi_event_sync

Parametrised multi-channel event synchronizer for the Acceptance Filter. It carries CHANNELS asynchronous status levels from the CAN_CLK domain (frame ready, error, bus-off, and similar) into the SYS_CLK domain through an N-stage synchronizer and an optional glitch filter. It then detects edges per a per-channel edge-select mode and holds each event as a sticky pending flag until the system side acknowledges it. Overflow is flagged when an event arrives before the previous one is acknowledged.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels, 1..32.
- SYNC_STAGES, 2: synchronizer flops per channel, 2..4.
- FILTER_LEN, 3: consecutive stable sys-clock samples required before the filtered level changes, 1..15. Used only when the filter is compiled in.

Ports:
- i_sys_clk, input, 1: system clock. All state is in this domain.
- i_reset, input, 1: reset, asynchronous, active-high.
- i_async, input, CHANNELS: asynchronous level inputs from the CAN_CLK domain.
- i_edge_sel, input, 2*CHANNELS: per-channel mode, bits [2c+1:2c]. 00 = rising, 01 = falling, 10 = both, 11 = disabled.
- i_ack, input, CHANNELS: per-channel acknowledge, one sys-clock pulse or level.
- o_level, output, CHANNELS: synchronized (and, with the filter, filtered) level.
- o_pulse, output, CHANNELS: one-cycle event strobe.
- o_pending, output, CHANNELS: sticky event flag.
- o_overflow, output, CHANNELS: sticky lost-event flag.

## Operation
- All flops reset to 0: sync chain, filter counter, level register, o_pulse, o_pending, o_overflow.
- A channel whose input is already high at reset release produces a rising event.
- Sync chain: s[0] <= i_async[c]; s[k] <= s[k-1]. sync_out = s[SYNC_STAGES-1].
- Filter counter, per channel, width $clog2(FILTER_LEN+1):
  - When sync_out == o_level, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the incremented value would reach FILTER_LEN, o_level toggles and the counter clears in the same edge.
  - A mismatch shorter than FILTER_LEN samples is discarded and produces no event.
- Edge detection, evaluated at the edge where o_level changes (new value v):
  - mode 00 fires if v = 1.
  - mode 01 fires if v = 0.
  - mode 10 fires always.
  - mode 11 never fires.
- A fire sets o_pulse for exactly one cycle.
- Changing i_edge_sel alone never generates a pulse. The new mode applies to the next o_level change.
- Pending/overflow update per channel per edge (P = pulse being issued this edge, A = i_ack):
  - P & !A: o_pending <= 1. If o_pending was already 1, o_overflow <= 1.
  - !P & A: o_pending <= 0, o_overflow <= 0.
  - P & A: o_pending <= 1, o_overflow <= 0. The acknowledged event is consumed; the new one is pending.
  - !P & !A: hold.
- Channels are fully independent. Simultaneous events on any set of channels are all captured.
- Asserting i_reset mid-operation clears everything asynchronously. Any in-flight event is lost. A high input re-fires as a rising event after release.

## Timing
- Input change captured at sys edge 0, meeting setup at s[0]: sync_out changes after edge SYNC_STAGES-1.
- o_level and o_pulse change at edge SYNC_STAGES+FILTER_LEN-1.
  - Without the filter: edge SYNC_STAGES.
  - Defaults: edge 4 with the filter, edge 2 without.
- o_pending rises at the same edge as o_pulse.
- Both o_pending and o_overflow clear at the edge sampling i_ack = 1.
- Minimum input pulse width guaranteed to be seen: FILTER_LEN+1 sys-clock periods (2 periods without the filter).
- Throughput: one event per channel per FILTER_LEN cycles (per cycle without the filter).

## Configuration
- CAN_ACF_SYNC_FILTER_EN defined: the glitch filter counter is present and FILTER_LEN applies as above.
- Not defined:
  - No counter logic is generated and FILTER_LEN is ignored.
  - o_level <= sync_out every cycle, which is identical to FILTER_LEN = 1.
  - Every level change of two or more cycles on sync_out produces an edge.

## Test plan
- Reset release with i_async[0] = 1, mode 00, filter on, defaults: o_pulse[0] high only in the cycle after edge 4; o_pending[0] = 1; all other outputs 0.
- 2-cycle high glitch on i_async[1], filter on, FILTER_LEN = 3: o_level[1], o_pulse[1], o_pending[1] stay 0. Repeat without the macro: one rising pulse, then one falling change with no pulse (mode 00).
- Mode 10 on channel 2, input high then low, each 10 cycles, no ack: two pulses; o_pending[2] = 1 and o_overflow[2] = 1 after the second pulse. A single i_ack[2] clears both.
- Pulse and i_ack on channel 3 in the same cycle while pending: o_pending[3] stays 1 and o_overflow[3] = 0.
- All 4 channels toggle in the same cycle, modes 00/01/10/11: pulses on channels 0 and 2 only at the rise; channels 1 and 2 only at the fall. o_level tracks on all four.
- i_reset asserted during the filter count on channel 0: all outputs 0 immediately. After release with the input still high, a full-latency rising pulse occurs.

Source files
------------

// File: rtl/can_acf_multi_event_sync.sv
// Multi-channel CAN_CLK -> SYS_CLK event synchronizer with edge select and sticky pending/overflow.
// Optional glitch filter compiled in with `define CAN_ACF_SYNC_FILTER_EN.
module can_acf_multi_event_sync #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic [CHANNELS-1:0]   i_async,
  input  logic [2*CHANNELS-1:0] i_edge_sel,
  input  logic [CHANNELS-1:0]   i_ack,
  output logic [CHANNELS-1:0]   o_level,
  output logic [CHANNELS-1:0]   o_pulse,
  output logic [CHANNELS-1:0]   o_pending,
  output logic [CHANNELS-1:0]   o_overflow
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_chk_channels
    $error("CHANNELS out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_stages
    $error("SYNC_STAGES out of range");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_chk_filter
    $error("FILTER_LEN out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CHANNELS-1:0]    sync_out;
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    pulse_q, pulse_d;
  logic [CHANNELS-1:0]    pending_q, pending_d;
  logic [CHANNELS-1:0]    overflow_q, overflow_d;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], i_async[c]};
      sync_out[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

`ifdef CAN_ACF_SYNC_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN);

  logic [CntW-1:0] cnt_q   [CHANNELS];
  logic [CntW-1:0] cnt_d   [CHANNELS];
  logic [CntW-1:0] cnt_inc [CHANNELS];

  // Level only moves after FILTER_LEN consecutive mismatching samples.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_inc[c] = cnt_q[c] + 1'b1;
      level_d[c] = level_q[c];
      cnt_d[c]   = '0;
      if (sync_out[c] != level_q[c]) begin
        if (cnt_inc[c] == CntMax) begin
          level_d[c] = ~level_q[c];
        end else begin
          cnt_d[c] = cnt_inc[c];
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end
`else
  always_comb begin
    level_d = sync_out;
  end
`endif

  always_comb begin
    pulse_d    = '0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (level_d[c] != level_q[c]) begin
        unique case (i_edge_sel[2*c +: 2])
          2'b00:   pulse_d[c] = level_d[c];
          2'b01:   pulse_d[c] = ~level_d[c];
          2'b10:   pulse_d[c] = 1'b1;
          default: pulse_d[c] = 1'b0;
        endcase
      end
      // A simultaneous ack consumes the old event; the new one stays pending.
      if (pulse_d[c] && !i_ack[c]) begin
        pending_d[c] = 1'b1;
        if (pending_q[c]) overflow_d[c] = 1'b1;
      end else if (i_ack[c]) begin
        pending_d[c]  = pulse_d[c];
        overflow_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < CHANNELS; c++) sync_q[c] <= '0;
      level_q    <= '0;
      pulse_q    <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) sync_q[c] <= sync_d[c];
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_level    = level_q;
  assign o_pulse    = pulse_q;
  assign o_pending  = pending_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_can_acf_multi_event_sync.sv
// Directed self-checking bench for can_acf_multi_event_sync at default parameters.
module tb_can_acf_multi_event_sync;

  localparam int unsigned CH = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned FL = 3;
`ifdef CAN_ACF_SYNC_FILTER_EN
  localparam int L    = SS + FL - 1;
  localparam bit FILT = 1'b1;
`else
  localparam int L    = SS;
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] async_in;
  logic [2*CH-1:0] esel;
  logic [CH-1:0] ack;
  logic [CH-1:0] o_level, o_pulse, o_pending, o_overflow;

  always #5 clk = ~clk;

  can_acf_multi_event_sync #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .FILTER_LEN (FL)
  ) u_dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .i_async   (async_in),
    .i_edge_sel(esel),
    .i_ack     (ack),
    .o_level   (o_level),
    .o_pulse   (o_pulse),
    .o_pending (o_pending),
    .o_overflow(o_overflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse(input logic [CH-1:0] m);
    ack = m;
    step(1);
    ack = '0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    async_in = '0;
    ack      = '0;
    step(2);
    rst = 1'b0;
  endtask

  int pc, lc;

  initial begin
    // Reset release with channel 0 already high
    rst = 1'b1; async_in = 4'b0001; ack = '0; esel = '0;
    step(2);
    check_eq("rst_level", 32'(o_level), 32'h0);
    check_eq("rst_pending", 32'(o_pending), 32'h0);
    rst = 1'b0;
    step(L);
    check_eq("t1_pulse_before", 32'(o_pulse), 32'h0);
    check_eq("t1_level_before", 32'(o_level), 32'h0);
    step(1);
    check_eq("t1_pulse", 32'(o_pulse), 32'h1);
    check_eq("t1_level", 32'(o_level), 32'h1);
    check_eq("t1_pending", 32'(o_pending), 32'h1);
    check_eq("t1_overflow", 32'(o_overflow), 32'h0);
    step(1);
    check_eq("t1_pulse_after", 32'(o_pulse), 32'h0);
    check_eq("t1_pending_hold", 32'(o_pending), 32'h1);
    ack_pulse(4'b0001);
    check_eq("t1_ack_clear", 32'(o_pending), 32'h0);

    // Two-cycle glitch on channel 1, mode 00
    pc = 0; lc = 0;
    async_in[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (i == 1) async_in[1] = 1'b0;
      pc += int'(o_pulse[1]);
      lc += int'(o_level[1]);
    end
    check_eq("t2_pulse_cnt", 32'(pc), FILT ? 32'd0 : 32'd1);
    check_eq("t2_level_cnt", 32'(lc), FILT ? 32'd0 : 32'd2);
    check_eq("t2_pending", 32'(o_pending[1]), FILT ? 32'd0 : 32'd1);
    ack_pulse(4'b0010);

    // Both-edge mode on channel 2, no ack -> overflow
    esel[5:4] = 2'b10;
    pc = 0;
    async_in[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      pc += int'(o_pulse[2]);
      if (i == 9) begin
        async_in[2] = 1'b0;
        check_eq("t3_pend_rise", 32'(o_pending[2]), 32'd1);
        check_eq("t3_ovf_rise", 32'(o_overflow[2]), 32'd0);
      end
    end
    check_eq("t3_pulse_cnt", 32'(pc), 32'd2);
    check_eq("t3_pending", 32'(o_pending[2]), 32'd1);
    check_eq("t3_overflow", 32'(o_overflow[2]), 32'd1);
    check_eq("t3_level", 32'(o_level[2]), 32'd0);
    ack_pulse(4'b0100);
    check_eq("t3_ack_pend", 32'(o_pending[2]), 32'd0);
    check_eq("t3_ack_ovf", 32'(o_overflow[2]), 32'd0);

    // Channel 3: build overflow, then pulse and ack in the same cycle
    async_in[3] = 1'b1; step(10);
    async_in[3] = 1'b0; step(10);
    check_eq("t4_pend_first", 32'(o_pending[3]), 32'd1);
    check_eq("t4_ovf_first", 32'(o_overflow[3]), 32'd0);
    async_in[3] = 1'b1; step(10);
    check_eq("t4_ovf_second", 32'(o_overflow[3]), 32'd1);
    async_in[3] = 1'b0; step(10);
    async_in[3] = 1'b1;
    step(L);
    ack[3] = 1'b1;
    step(1);
    ack = '0;
    check_eq("t4_pulse", 32'(o_pulse[3]), 32'd1);
    check_eq("t4_pending", 32'(o_pending[3]), 32'd1);
    check_eq("t4_overflow", 32'(o_overflow[3]), 32'd0);

    // All channels toggle together, modes 00/01/10/11
    esel = 8'b11_10_01_00;
    do_reset();
    async_in = 4'hF;
    step(L);
    check_eq("t5_pulse_pre", 32'(o_pulse), 32'h0);
    step(1);
    check_eq("t5_rise_pulse", 32'(o_pulse), 32'h5);
    check_eq("t5_rise_level", 32'(o_level), 32'hF);
    check_eq("t5_rise_pend", 32'(o_pending), 32'h5);
    step(1);
    check_eq("t5_rise_done", 32'(o_pulse), 32'h0);
    step(8);
    async_in = 4'h0;
    step(L);
    check_eq("t5_fall_pre", 32'(o_level), 32'hF);
    step(1);
    check_eq("t5_fall_pulse", 32'(o_pulse), 32'h6);
    check_eq("t5_fall_level", 32'(o_level), 32'h0);
    check_eq("t5_fall_pend", 32'(o_pending), 32'h7);
    check_eq("t5_fall_ovf", 32'(o_overflow), 32'h4);

    // Reset mid-count on channel 0 while channel 1 holds an event
    esel = '0;
    do_reset();
    async_in = 4'b0010;
    step(L + 1);
    check_eq("t6_pend_pre", 32'(o_pending), 32'h2);
    async_in = 4'b0011;
    step(L - 1);
    rst = 1'b1;
    #1;
    check_eq("t6_async_level", 32'(o_level), 32'h0);
    check_eq("t6_async_pend", 32'(o_pending), 32'h0);
    check_eq("t6_async_pulse", 32'(o_pulse), 32'h0);
    rst = 1'b0;
    step(L);
    check_eq("t6_refire_pre", 32'(o_pulse), 32'h0);
    step(1);
    check_eq("t6_refire_pulse", 32'(o_pulse), 32'h3);
    check_eq("t6_refire_level", 32'(o_level), 32'h3);
    check_eq("t6_refire_pend", 32'(o_pending), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
